control_sequencer: RTL and testbench

- Instruction sequencer that drives every control input of the ALU system datapath: multiplexer selects, RF/ARF/IR controls, ALU function, memory chip-select and write.
- Fetches a 16-bit instruction from memory as two bytes into the IR (low byte, then high byte), advancing the PC after each byte.
- Decodes the opcode and issues a single execute cycle, then repeats.
- Sits beside the datapath in the top level; it is the controlling end of the datapath's control interface.

---
 rtl/control_sequencer.sv | 169 ++++++++++++++++
 tb/tb_control_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Instruction sequencer for the ALU system: two-byte fetch into IR, one execute cycle.
// Only the state is registered; every control output decodes from state and IR_Out.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset_N,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  Flags,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic [1:0]  IR_Funsel,
  output logic        IR_Enable,
  output logic        IR_LH,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        Halted,
  output logic        Illegal
);

  localparam logic [1:0] FS_DEC    = 2'b00;
  localparam logic [1:0] FS_INC    = 2'b01;
  localparam logic [1:0] FS_LOAD   = 2'b10;
  localparam logic [1:0] FS_CLR    = 2'b11;
  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;

  localparam logic [1:0] ARF_PC = 2'd0;
  localparam logic [1:0] ARF_AR = 2'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_L = 3'd1,
    FETCH_H = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [3:0] opc;
  logic [1:0] rd, rs1, rs2;
  logic [3:0] rd_en;

  assign opc   = IR_Out[15:12];
  assign rd    = IR_Out[11:10];
  assign rs1   = IR_Out[9:8];
  assign rs2   = IR_Out[7:6];
  assign rd_en = 4'b1000 >> rd;

  // Immediate bits reach the RF through MuxA inside the datapath; only Z is consulted here.
  logic unused_bits;
  assign unused_bits = ^{IR_Out[5:0], Flags[2:0], FS_DEC, FS_CLR};

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    MuxASel     = 2'd0;
    MuxBSel     = 2'd0;
    MuxCSel     = 1'b0;
    RF_OutASel  = 3'd0;
    RF_OutBSel  = 3'd0;
    RF_FunSel   = 2'd0;
    RF_RSel     = 4'd0;
    RF_TSel     = 4'd0;
    ALU_FunSel  = 4'd0;
    ARF_OutASel = 2'd0;
    ARF_OutBSel = 2'd0;
    ARF_FunSel  = 2'd0;
    ARF_RSel    = 4'd0;
    IR_Funsel   = 2'd0;
    IR_Enable   = 1'b0;
    IR_LH       = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    Halted      = 1'b0;
    Illegal     = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH_L;
      FETCH_L, FETCH_H: begin
        ARF_OutBSel = ARF_PC;
        Mem_CS      = 1'b0;
        IR_Enable   = 1'b1;
        IR_Funsel   = FS_LOAD;
        IR_LH       = (state_q == FETCH_H);
        ARF_RSel    = 4'b1000;
        ARF_FunSel  = FS_INC;
        state_d     = (state_q == FETCH_H) ? EXEC : FETCH_H;
      end
      EXEC: begin
        state_d = FETCH_L;
        unique case (opc)
          4'h0: begin
            MuxASel   = 2'd2;
            RF_FunSel = FS_LOAD;
            RF_RSel   = rd_en;
          end
          4'h1: begin
            ARF_OutBSel = ARF_AR;
            Mem_CS      = 1'b0;
            MuxASel     = 2'd1;
            RF_FunSel   = FS_LOAD;
            RF_RSel     = rd_en;
          end
          4'h2: begin
            ARF_OutBSel = ARF_AR;
            RF_OutBSel  = {1'b0, rd};
            ALU_FunSel  = ALU_PASSB;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          4'h3: begin
            RF_OutASel = {1'b0, rs1};
            ALU_FunSel = ALU_PASSA;
            RF_FunSel  = FS_LOAD;
            RF_RSel    = rd_en;
          end
          4'h4, 4'h5, 4'h6, 4'h7: begin
            RF_OutASel = {1'b0, rs1};
            RF_OutBSel = {1'b0, rs2};
            unique case (opc[1:0])
              2'd0:    ALU_FunSel = ALU_ADD;
              2'd1:    ALU_FunSel = ALU_SUB;
              2'd2:    ALU_FunSel = ALU_AND;
              default: ALU_FunSel = ALU_OR;
            endcase
            RF_FunSel = FS_LOAD;
            RF_RSel   = rd_en;
          end
          4'h8, 4'h9: begin
            // BZ shares the branch path but only writes PC when Z is set this cycle.
            if (opc == 4'h8 || Flags[3]) begin
              MuxBSel    = 2'd2;
              ARF_FunSel = FS_LOAD;
              ARF_RSel   = 4'b1000;
            end
          end
          4'hA: begin
            MuxBSel    = 2'd2;
            ARF_FunSel = FS_LOAD;
            ARF_RSel   = 4'b0100;
          end
          4'hF:    state_d = HALT;
          default: Illegal = 1'b1;
        endcase
      end
      HALT: Halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, every opcode class, BZ both ways, illegal, halt, resets.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_N;
  logic [15:0] IR_Out;
  logic [3:0]  Flags;
  logic [1:0]  MuxASel, MuxBSel, RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel;
  logic        MuxCSel, IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;

  int nchk = 0;
  int nerr = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset_N(Reset_N), .IR_Out(IR_Out), .Flags(Flags),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // All outputs packed; Mem_CS is bit 2, Halted bit 1, Illegal bit 0.
  logic [42:0] ovec;
  assign ovec = {MuxASel, MuxBSel, MuxCSel, RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel,
                 RF_TSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
                 IR_Funsel, IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal};

  localparam logic [42:0] V_IDLE = 43'h4;
  localparam logic [42:0] V_HALT = 43'h6;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch_l(input string tag);
    chk({tag, ".en"},   IR_Enable, 1'b1);
    chk({tag, ".lh"},   IR_LH, 1'b0);
    chk({tag, ".irfs"}, IR_Funsel, 2'd2);
    chk({tag, ".arsel"}, ARF_RSel, 4'b1000);
    chk({tag, ".arfs"}, ARF_FunSel, 2'd1);
    chk({tag, ".cs"},   Mem_CS, 1'b0);
    chk({tag, ".outb"}, ARF_OutBSel, 2'd0);
    chk({tag, ".rsel"}, RF_RSel, 4'd0);
  endtask

  // Entered at a negedge in FETCH_L; returns at the negedge inside EXEC.
  task automatic fetch(input logic [15:0] ir, input logic [3:0] fl);
    chk_fetch_l("fl");
    IR_Out = ir;
    Flags  = fl;
    @(negedge Clock);
    chk("fh.lh", IR_LH, 1'b1);
    chk("fh.en", IR_Enable, 1'b1);
    chk("fh.arsel", ARF_RSel, 4'b1000);
    @(negedge Clock);
  endtask

  initial begin
    Reset_N = 1'b0;
    IR_Out  = 16'h0;
    Flags   = 4'h0;
    repeat (2) @(negedge Clock);
    chk("rst.vec", ovec, V_IDLE);
    chk("rst.halted", Halted, 1'b0);
    Reset_N = 1'b1;
    #1 chk("idle.vec", ovec, V_IDLE);
    @(negedge Clock);
    chk_fetch_l("first");

    fetch(16'h0C5A, 4'h0);  // LDI R4
    chk("ldi.muxa", MuxASel, 2'd2);
    chk("ldi.fs", RF_FunSel, 2'd2);
    chk("ldi.rsel", RF_RSel, 4'b0001);
    chk("ldi.iren", IR_Enable, 1'b0);
    chk("ldi.cs", Mem_CS, 1'b1);
    chk("ldi.arsel", ARF_RSel, 4'd0);
    @(negedge Clock);

    fetch(16'h47C0, 4'h0);  // ADD R2 <- R4 + R4
    chk("add.alu", ALU_FunSel, 4'b0100);
    chk("add.oa", RF_OutASel, 3'd3);
    chk("add.ob", RF_OutBSel, 3'd3);
    chk("add.rsel", RF_RSel, 4'b0100);
    chk("add.muxc", MuxCSel, 1'b0);
    chk("add.muxa", MuxASel, 2'd0);
    chk("add.fs", RF_FunSel, 2'd2);
    @(negedge Clock);

    fetch(16'h2800, 4'h0);  // STM R3 -> M[AR]
    chk("stm.cs", Mem_CS, 1'b0);
    chk("stm.wr", Mem_WR, 1'b1);
    chk("stm.outb", ARF_OutBSel, 2'd1);
    chk("stm.rfob", RF_OutBSel, 3'd2);
    chk("stm.alu", ALU_FunSel, 4'b0001);
    chk("stm.rsel", RF_RSel, 4'd0);
    chk("stm.iren", IR_Enable, 1'b0);
    @(negedge Clock);

    fetch(16'h1400, 4'h0);  // LDM R2
    chk("ldm.cs", Mem_CS, 1'b0);
    chk("ldm.wr", Mem_WR, 1'b0);
    chk("ldm.outb", ARF_OutBSel, 2'd1);
    chk("ldm.muxa", MuxASel, 2'd1);
    chk("ldm.rsel", RF_RSel, 4'b0100);
    @(negedge Clock);

    fetch(16'h3E00, 4'h0);  // MOV R4 <- R3
    chk("mov.oa", RF_OutASel, 3'd2);
    chk("mov.alu", ALU_FunSel, 4'b0000);
    chk("mov.rsel", RF_RSel, 4'b0001);
    @(negedge Clock);

    fetch(16'h5240, 4'h0);  // SUB R1 <- R3 - R2
    chk("sub.alu", ALU_FunSel, 4'b0110);
    chk("sub.oa", RF_OutASel, 3'd2);
    chk("sub.ob", RF_OutBSel, 3'd1);
    chk("sub.rsel", RF_RSel, 4'b1000);
    @(negedge Clock);

    fetch(16'h6000, 4'h0);  // AND
    chk("and.alu", ALU_FunSel, 4'b0111);
    @(negedge Clock);

    fetch(16'h7C00, 4'h0);  // OR R4
    chk("or.alu", ALU_FunSel, 4'b1000);
    chk("or.rsel", RF_RSel, 4'b0001);
    @(negedge Clock);

    fetch(16'h9020, 4'b1000);  // BZ taken
    chk("bzt.muxb", MuxBSel, 2'd2);
    chk("bzt.arsel", ARF_RSel, 4'b1000);
    chk("bzt.arfs", ARF_FunSel, 2'd2);
    @(negedge Clock);

    fetch(16'h9020, 4'b0111);  // BZ not taken: other flags must not matter
    chk("bzn.arsel", ARF_RSel, 4'd0);
    chk("bzn.arfs", ARF_FunSel, 2'd0);
    chk("bzn.rsel", RF_RSel, 4'd0);
    chk("bzn.cs", Mem_CS, 1'b1);
    @(negedge Clock);

    fetch(16'h8010, 4'h0);  // BRA
    chk("bra.muxb", MuxBSel, 2'd2);
    chk("bra.arsel", ARF_RSel, 4'b1000);
    chk("bra.arfs", ARF_FunSel, 2'd2);
    @(negedge Clock);

    fetch(16'hA033, 4'h0);  // LDAR
    chk("ldar.muxb", MuxBSel, 2'd2);
    chk("ldar.arsel", ARF_RSel, 4'b0100);
    chk("ldar.arfs", ARF_FunSel, 2'd2);
    @(negedge Clock);

    fetch(16'hB000, 4'h0);  // undefined opcode
    chk("ill.pulse", Illegal, 1'b1);
    chk("ill.rsel", RF_RSel, 4'd0);
    chk("ill.cs", Mem_CS, 1'b1);
    @(negedge Clock);
    chk("ill.clr", Illegal, 1'b0);
    chk_fetch_l("ill.next");
    IR_Out = 16'hE000;
    @(negedge Clock);
    @(negedge Clock);
    chk("ill.e", Illegal, 1'b1);
    @(negedge Clock);

    // Reset in the middle of a fetch restarts from IDLE.
    @(negedge Clock);
    chk("mid.lh", IR_LH, 1'b1);
    #2 Reset_N = 1'b0;
    #1 chk("mid.async", ovec, V_IDLE);
    @(negedge Clock);
    chk("mid.hold", ovec, V_IDLE);
    Reset_N = 1'b1;
    @(negedge Clock);
    chk_fetch_l("mid.refetch");

    fetch(16'hF000, 4'h0);  // HLT
    chk("hlt.exec", Halted, 1'b0);
    chk("hlt.ill", Illegal, 1'b0);
    chk("hlt.rsel", RF_RSel, 4'd0);
    for (int i = 0; i < 22; i++) begin
      @(negedge Clock);
      chk($sformatf("halt.%0d", i), ovec, V_HALT);
    end
    Reset_N = 1'b0;
    #1 chk("halt.rst", ovec, V_IDLE);
    @(negedge Clock);
    Reset_N = 1'b1;
    @(negedge Clock);
    chk_fetch_l("halt.restart");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
